// File: rtl/z80_mem_cycle_master.sv
// z80_mem_cycle_master
// Bus initiator for the VG8020 memory bus. Turns a single-word request into a
// Z80-style memory cycle (T1, T2, optional TW, T3) on nmreq/nrd/nwr with
// address and data. Every bus output is a flop; nothing passes
// combinationally from an input to an output.
//
// Optional feature: define Z80_MEM_CYCLE_WAIT_TIMEOUT_EN to bound the number of
// consecutive TW states to MAX_WAIT. When the bound is hit the cycle ends in T3
// with err=1 and rdata left untouched. Without the macro, TW is unbounded and
// err is always 0.
//
// Request handshake: a request is taken when req=1 and ready=1 at a rising
// edge. we/addr/wdata are captured at that edge; ready then stays low until
// the cycle has finished and the block is back in IDLE. req seen while ready=0
// is ignored. done is a one-clock pulse in T3 of every completed cycle, and err
// is valid only while done=1.
//
// d_in is the sampled data bus, read at the edge that ends T2/TW with nwait=1.
// dbg_state exposes the FSM state (0=IDLE, 1=T1, 2=T2, 3=TW, 4=T3).

module z80_mem_cycle_master #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        nmreq,
  output logic        nrd,
  output logic        nwr,
  input  logic        nwait,
  input  logic [7:0]  d_in,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4
  } state_t;

  // Elaboration-time guard on the wait bound.
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("z80_mem_cycle_master: MAX_WAIT must be in 1..255");
  end

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        nmreq_q, nmreq_d;
  logic        nrd_q, nrd_d;
  logic        nwr_q, nwr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        accept;
  logic        timeout_hit;
  logic        bus_active;
  logic        strobe_phase;

  assign accept = (state_q == S_IDLE) && req;

`ifdef Z80_MEM_CYCLE_WAIT_TIMEOUT_EN
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wcnt_q, wcnt_d;

  // Wait counter: cleared on entry to T2, one step per TW cycle entered.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d == S_T2) begin
      wcnt_d = 8'd0;
    end else if (state_d == S_TW) begin
      wcnt_d = wcnt_q + 8'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wcnt_q <= 8'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign timeout_hit = (state_q == S_TW) && (wcnt_q == MAX_WAIT_C);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: nwait is sampled at the edges that end T2 and TW.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = nwait ? S_T3 : S_TW;
      S_TW: begin
        if (nwait) begin
          state_d = S_T3;
        end else if (timeout_hit) begin
          state_d = S_T3;
        end
      end
      S_T3:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus signals, derived from the
  // state being entered so the pins change exactly at the state boundary.
  always_comb begin
    we_d         = accept ? we : we_q;
    bus_active   = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_TW);
    strobe_phase = (state_d == S_T2) || (state_d == S_TW);

    // Address is captured with the request and held through IDLE afterwards.
    a_d     = accept ? addr : a_q;
    // Write data is driven from T1; reads leave the last drive value alone.
    d_out_d = (accept && we) ? wdata : d_out_q;
    // Data bus stays enabled through T3 to give write data hold time.
    d_oe_d  = we_d && (state_d != S_IDLE);

    nmreq_d = !bus_active;
    nrd_d   = !(bus_active && !we_d);
    nwr_d   = !(strobe_phase && we_d);

    done_d  = (state_d == S_T3);
    // err marks a T3 reached through the wait bound rather than nwait=1.
    err_d   = (state_q == S_TW) && !nwait && timeout_hit;
    ready_d = (state_d == S_IDLE);

    // Read data is latched only at an edge that ends T2/TW with nwait=1.
    rdata_d = rdata_q;
    if (((state_q == S_T2) || (state_q == S_TW)) && nwait && !we_q) begin
      rdata_d = d_in;
    end
  end

  // Output and capture registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      we_q    <= 1'b0;
      a_q     <= 16'h0000;
      d_out_q <= 8'h00;
      d_oe_q  <= 1'b0;
      nmreq_q <= 1'b1;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      rdata_q <= 8'h00;
    end else begin
      we_q    <= we_d;
      a_q     <= a_d;
      d_out_q <= d_out_d;
      d_oe_q  <= d_oe_d;
      nmreq_q <= nmreq_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign a         = a_q;
  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
  assign nmreq     = nmreq_q;
  assign nrd       = nrd_q;
  assign nwr       = nwr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_z80_mem_cycle_master.sv
// Testbench for z80_mem_cycle_master. The reference model describes a cycle
// as a timeline: after acceptance come T1, then T2 plus W wait cycles, then
// T3, then IDLE, where W is the number of low nwait samples (capped at MAXW
// when the timeout feature is compiled in).

module tb_z80_mem_cycle_master;

  localparam int MAXW = 4;
`ifdef Z80_MEM_CYCLE_WAIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        nreset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        nmreq;
  logic        nrd;
  logic        nwr;
  logic        nwait;
  logic [7:0]  d_in;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Model state: what the pins should hold between cycles.
  logic [15:0] m_a;
  logic [7:0]  m_dout;
  logic [7:0]  m_rdata;
  logic [7:0]  exp_q[$];

  z80_mem_cycle_master #(.MAX_WAIT(MAXW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .a         (a),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .nmreq     (nmreq),
    .nrd       (nrd),
    .nwr       (nwr),
    .nwait     (nwait),
    .d_in      (d_in),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete cycle against the timeline model. Called one step after an
  // edge with the DUT in IDLE; returns one step after the edge into IDLE.
  task automatic run_txn(input string tag, input logic t_we, input logic [15:0] t_addr,
                         input logic [7:0] t_wdata, input logic [7:0] t_bus,
                         input int n_low, input bit hold);
    int w;
    bit to;
    logic [6:0] exp_ctl;
    logic [6:0] got_ctl;
    logic [7:0] exp_r;
    logic [7:0] r_old;
    logic [7:0] sb;
    to = TO_EN && (n_low > MAXW);
    w  = to ? MAXW : n_low;

    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_start got=%b exp=1", tag, ready);
    end

    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    nwait = 1'b1;
    d_in  = 8'($urandom);
    step();

    m_a = t_addr;
    if (t_we) m_dout = t_wdata;
    r_old = m_rdata;
    if (!t_we && !to) m_rdata = t_bus;
    exp_q.push_back(m_rdata);

    // Inputs change after capture; none of this may reach the bus.
    req   = hold;
    we    = ~t_we;
    addr  = t_addr ^ 16'h8421;
    wdata = ~t_wdata;

    for (int k = 0; k <= w + 3; k++) begin
      // {nmreq, nrd, nwr, d_oe, done, err, ready}
      if (k == 0)           exp_ctl = {1'b0, t_we, 1'b1, t_we, 3'b000};
      else if (k <= w + 1)  exp_ctl = {1'b0, t_we, ~t_we, t_we, 3'b000};
      else if (k == w + 2)  exp_ctl = {3'b111, t_we, 1'b1, to, 1'b0};
      else                  exp_ctl = {3'b111, 1'b0, 3'b001};
      exp_r   = (k >= w + 2) ? m_rdata : r_old;
      got_ctl = {nmreq, nrd, nwr, d_oe, done, err, ready};

      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s k=%0d ctl got=%b exp=%b", tag, k, got_ctl, exp_ctl);
      end
      checks++;
      if (a !== m_a) begin
        errors++;
        $display("FAIL %s k=%0d addr got=%h exp=%h", tag, k, a, m_a);
      end
      checks++;
      if (d_out !== m_dout) begin
        errors++;
        $display("FAIL %s k=%0d d_out got=%h exp=%h", tag, k, d_out, m_dout);
      end
      checks++;
      if (rdata !== exp_r) begin
        errors++;
        $display("FAIL %s k=%0d rdata got=%h exp=%h", tag, k, rdata, exp_r);
      end
      if (k == w + 2) begin
        sb = exp_q.pop_front();
        checks++;
        if (rdata !== sb) begin
          errors++;
          $display("FAIL %s scoreboard rdata got=%h exp=%h", tag, rdata, sb);
        end
      end

      // Drive nwait / bus data for the edge that ends this cycle.
      nwait = (k >= 1 && k <= w + 1 && k <= n_low) ? 1'b0 : 1'b1;
      d_in  = (k == w + 1) ? t_bus : (t_bus ^ 8'($urandom_range(1, 255)));
      if (k < w + 3) step();
    end
    nwait = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] got_ctl;
    nreset = 1'b0;
    req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 8'h0; nwait = 1'b1; d_in = 8'h0;
    repeat (3) step();
    got_ctl = {nmreq, nrd, nwr, d_oe, done, err, ready};
    checks++;
    if (got_ctl !== 7'b1110001) begin
      errors++;
      $display("FAIL reset ctl got=%b exp=%b", got_ctl, 7'b1110001);
    end
    checks++;
    if ({a, d_out, rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset buses got=%h exp=0", {a, d_out, rdata});
    end
    nreset = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready got=%b exp=1", ready);
    end
    m_a = 16'h0; m_dout = 8'h0; m_rdata = 8'h0;
  endtask

  task automatic test_read_basic();
    run_txn("read_basic", 1'b0, 16'h1234, 8'h00, 8'hA5, 0, 1'b0);
  endtask

  task automatic test_write_basic();
    run_txn("write_basic", 1'b1, 16'hC000, 8'h5A, 8'h00, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_txn("read_wait3", 1'b0, 16'h4321, 8'h00, 8'h3C, 3, 1'b0);
    run_txn("write_wait2", 1'b1, 16'h0F0F, 8'hE1, 8'h00, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [6:0] got_ctl;
    req = 1'b1; we = 1'b1; addr = 16'hBEEF; wdata = 8'h3C; nwait = 1'b0;
    step();                      // T1
    req = 1'b0;
    step();                      // T2
    step();                      // TW
    checks++;
    if ({nmreq, nwr, d_oe} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid in_tw got=%b exp=001", {nmreq, nwr, d_oe});
    end
    nreset = 1'b0;
    step();
    got_ctl = {nmreq, nrd, nwr, d_oe, done, err, ready};
    checks++;
    if (got_ctl !== 7'b1110001) begin
      errors++;
      $display("FAIL reset_mid ctl got=%b exp=%b", got_ctl, 7'b1110001);
    end
    checks++;
    if ({a, d_out} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid buses got=%h exp=0", {a, d_out});
    end
    nreset = 1'b1;
    nwait  = 1'b1;
    step();
    checks++;
    if ({done, ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid after got=%b exp=01", {done, ready});
    end
    m_a = 16'h0; m_dout = 8'h0; m_rdata = 8'h0;
    run_txn("after_reset", 1'b0, 16'h7777, 8'h00, 8'h96, 1, 1'b0);
  endtask

  task automatic test_req_held();
    run_txn("held_first", 1'b0, 16'h1111, 8'h00, 8'h11, 1, 1'b1);
    run_txn("held_second", 1'b1, 16'h2222, 8'h22, 8'h00, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_0", 1'b1, 16'hAAAA, 8'h01, 8'h00, 0, 1'b0);
    run_txn("b2b_1", 1'b0, 16'h5555, 8'h00, 8'hFE, 0, 1'b0);
    run_txn("b2b_2", 1'b1, 16'hFFFF, 8'h80, 8'h00, 0, 1'b0);
  endtask

  task automatic test_timeout();
    // Stuck-low nwait: bounded by MAXW when the timeout is built in,
    // otherwise the cycle waits all 12 samples with done held low.
    run_txn("timeout_rd", 1'b0, 16'h0ABC, 8'h00, 8'h77, 12, 1'b0);
    run_txn("timeout_wr", 1'b1, 16'h0DEF, 8'hC3, 8'h00, MAXW + 1, 1'b0);
    run_txn("at_bound", 1'b0, 16'h0123, 8'h00, 8'h42, MAXW, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_txn("random", 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_wait_states();
    test_reset_mid();
    test_req_held();
    test_back_to_back();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
